div32_seq: RTL and testbench
============================

Name: div32_seq

Overview:
- Multi-cycle radix-2 restoring divider: quotient and remainder of two WIDTH-bit operands.
- Each cycle performs one trial subtraction through a WIDTH+1-bit subtract path, i.e. the adder datapath run in the subtract direction.
- Sits beside the ALU adder as the DIV/REM execution unit.
- Start/done handshake, one operation in flight.

Parameters:
- WIDTH, 32, operand/result width in bits (≥2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  request; sampled only in IDLE
- is_signed  input  1  1 = two's-complement divide, 0 = unsigned; sampled with start
- dividend  input  WIDTH  numerator; sampled with start
- divisor  input  WIDTH  denominator; sampled with start
- busy  output  1  high while in CALC
- done  output  1  one-cycle pulse, results valid
- quotient  output  WIDTH  registered quotient; held until next accepted start
- remainder  output  WIDTH  registered remainder; held until next accepted start
- div_by_zero  output  1  registered flag for the last operation; held like results

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; counter=0. Reset mid-operation aborts immediately with no done pulse.
- States: IDLE, CALC, DONE.
- IDLE with start=1 at edge E0:
  - divisor≠0: latch the operand magnitudes (absolute values if is_signed, else raw) and latch the sign flags. Set rem_work=0, quo_work=|dividend|, cnt=0. Clear div_by_zero. Go to CALC.
  - divisor=0: quotient=all ones, remainder=dividend (raw), div_by_zero=1. Go to DONE (done asserted in the cycle after E0).
- CALC, each edge:
  - Shift {rem_work,quo_work} left 1.
  - Trial = rem_work_shifted − |divisor| on WIDTH+1 bits.
  - If the trial is non-negative: rem_work=trial, quo LSB=1. Otherwise restore and quo LSB=0.
  - cnt++.
- After exactly WIDTH CALC edges (edge E_WIDTH), in the same edge:
  - Quotient = quo_work, negated if is_signed and sign(dividend)≠sign(divisor).
  - Remainder = rem_work, negated if is_signed and dividend negative.
  - Outputs written; go to DONE.
- DONE: done=1 for exactly one cycle, busy=0; next edge → IDLE.
- Latency: start sampled at E0, done high during the cycle between E_WIDTH and E_WIDTH+1 (33 cycles for WIDTH=32). Back-to-back: a new start can be accepted on the edge leaving DONE→IDLE+1, i.e. the first IDLE cycle.
- start while CALC or DONE: ignored; operands and is_signed are not re-sampled.
- Signed overflow (MIN / −1): quotient=MIN (0x80000000), remainder=0, div_by_zero=0. This is the natural result of the magnitude algorithm; no special case is needed.
- Remainder sign follows the dividend (truncating division); |remainder| < |divisor|.
- busy and done are never high together.

Optional Feature:
- Macro: DIV_SIGNED_EN.
- Defined: is_signed honoured as above (magnitude conversion plus final negation).
- Undefined: is_signed port is present but ignored; all operations are unsigned; the sign-fixup logic is not built.

Test Plan:
- Unsigned 100/7, is_signed=0, start pulse at E0 → busy high for 32 cycles, done pulse in cycle 33; quotient=14, remainder=2, div_by_zero=0.
- Signed −7/2 (0xFFFFFFF9 / 0x2), is_signed=1 → quotient=0xFFFFFFFD (−3), remainder=0xFFFFFFFF (−1). With DIV_SIGNED_EN undefined, the same inputs → quotient=0x7FFFFFFC, remainder=1.
- Divide by zero 0x12345678/0 → done in the cycle after E0, never busy; quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1.
- Signed MIN/−1 (0x80000000 / 0xFFFFFFFF) → quotient=0x80000000, remainder=0, div_by_zero=0.
- start held high with new operands (50/5) during CALC of 100/7 → result still 14 r 2. Then 50/5 is accepted in the first IDLE cycle → 10 r 0 after a further 33 cycles.
- rst asserted at CALC cycle 10 → all outputs 0 immediately, no done pulse. A fresh 9/3 after release → 3 r 0.

Source files
------------

// File: rtl/div32_seq.sv
// Multi-cycle radix-2 restoring divider: one quotient bit per cycle via a WIDTH+1-bit trial subtract.
// Signed support (magnitude conversion and final negation) is built only when DIV_SIGNED_EN is defined.
module div32_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] rem_work, quo_work, dvsr_mag;
   logic [CW-1:0]    cnt;

   logic [WIDTH-1:0] dvd_mag, dvs_mag;
   logic [WIDTH:0]   rem_sh, trial;
   logic [WIDTH-1:0] rem_next, quo_next;
   logic [WIDTH-1:0] q_fix, r_fix;
   logic             last_step;

   // The shifted partial remainder is below 2*divisor, so a non-negative trial always fits in WIDTH bits.
   always_comb begin
      rem_sh = {rem_work, quo_work[WIDTH-1]};
      trial  = rem_sh - {1'b0, dvsr_mag};
      if (!trial[WIDTH]) begin
         rem_next = trial[WIDTH-1:0];
         quo_next = {quo_work[WIDTH-2:0], 1'b1};
      end else begin
         rem_next = rem_sh[WIDTH-1:0];
         quo_next = {quo_work[WIDTH-2:0], 1'b0};
      end
   end

   assign last_step = (cnt == CW'(WIDTH - 1));

`ifdef DIV_SIGNED_EN
   logic dvd_neg, dvs_neg;
   logic neg_q, neg_r;

   assign dvd_neg = is_signed & dividend[WIDTH-1];
   assign dvs_neg = is_signed & divisor[WIDTH-1];
   assign dvd_mag = dvd_neg ? -dividend : dividend;
   assign dvs_mag = dvs_neg ? -divisor  : divisor;
   assign q_fix   = neg_q ? -quo_next : quo_next;
   assign r_fix   = neg_r ? -rem_next : rem_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else if (state == IDLE && start) begin
         neg_q <= dvd_neg ^ dvs_neg;
         neg_r <= dvd_neg;
      end
   end
`else
   logic unused_is_signed;

   assign unused_is_signed = is_signed;
   assign dvd_mag = dividend;
   assign dvs_mag = divisor;
   assign q_fix   = quo_next;
   assign r_fix   = rem_next;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         cnt         <= '0;
         rem_work    <= '0;
         quo_work    <= '0;
         dvsr_mag    <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  if (divisor == '0) begin
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                     done        <= 1'b1;
                     state       <= DONE;
                  end else begin
                     rem_work    <= '0;
                     quo_work    <= dvd_mag;
                     dvsr_mag    <= dvs_mag;
                     cnt         <= '0;
                     div_by_zero <= 1'b0;
                     busy        <= 1'b1;
                     state       <= CALC;
                  end
               end
            end
            CALC: begin
               rem_work <= rem_next;
               quo_work <= quo_next;
               cnt      <= cnt + 1'b1;
               if (last_step) begin
                  quotient  <= q_fix;
                  remainder <= r_fix;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div32_seq.sv
// Directed-vector bench for div32_seq: driver pushes expected results, a negedge monitor pops on done.
module tb_div32_seq;
   localparam int W = 32;
`ifdef DIV_SIGNED_EN
   localparam bit SE = 1'b1;
`else
   localparam bit SE = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst, start, is_signed;
   logic [W-1:0] dividend, divisor;
   logic         busy, done, div_by_zero;
   logic [W-1:0] quotient, remainder;

   // Each entry is {div_by_zero, quotient, remainder}.
   logic [2*W:0] exp_q[$];
   int           checks = 0;
   int           errors = 0;

   div32_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
      .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
      .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (!rst) begin
         if (busy && done) begin
            checks++;
            errors++;
            $display("FAIL busy_done_overlap: got busy=1 done=1 expected never both");
         end
         if (done) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done=1 expected no pending operation");
            end else begin
               logic [2*W:0] e;
               e = exp_q.pop_front();
               chk("quotient", quotient, e[2*W-1:W]);
               chk("remainder", remainder, e[W-1:0]);
               chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, e[2*W]});
            end
         end
      end
   end

   task automatic wait_done(input int exp_lat, input int exp_busy);
      int n = 0;
      int bc = 0;
      bit seen = 1'b0;
      while (!seen && n < 100) begin
         @(negedge clk);
         n++;
         if (busy) bc++;
         if (done) seen = 1'b1;
      end
      chk("latency", n, exp_lat);
      chk("busy_cycles", bc, exp_busy);
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                         input int lat, input int bsy);
      exp_q.push_back({edz, eq, er});
      @(negedge clk);
      dividend  = a;
      divisor   = b;
      is_signed = s;
      start     = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(lat, bsy);
   endtask

   initial begin
      int dn;
      rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
      repeat (3) @(negedge clk);
      chk("rst_quotient", quotient, 32'h0);
      chk("rst_remainder", remainder, 32'h0);
      chk("rst_dbz", {31'b0, div_by_zero}, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'h0);
      chk("rst_done", {31'b0, done}, 32'h0);
      rst = 1'b0;

      run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 33, 32);
      run_op(32'hFFFFFFF9, 32'h2, 1'b1,
             SE ? 32'hFFFFFFFD : 32'h7FFFFFFC, SE ? 32'hFFFFFFFF : 32'h1, 1'b0, 33, 32);
      run_op(32'd7, 32'hFFFFFFFE, 1'b1,
             SE ? 32'hFFFFFFFD : 32'h0, SE ? 32'h1 : 32'h7, 1'b0, 33, 32);
      run_op(32'h12345678, 32'h0, 1'b0, 32'hFFFFFFFF, 32'h12345678, 1'b1, 1, 0);
      run_op(32'h80000000, 32'hFFFFFFFF, 1'b1,
             SE ? 32'h80000000 : 32'h0, SE ? 32'h0 : 32'h80000000, 1'b0, 33, 32);
      run_op(32'hFFFFFFFF, 32'h10, 1'b0, 32'h0FFFFFFF, 32'hF, 1'b0, 33, 32);

      // start held high with new operands during CALC; only accepted once back in IDLE
      exp_q.push_back({1'b0, 32'd14, 32'd2});
      exp_q.push_back({1'b0, 32'd10, 32'd0});
      @(negedge clk);
      dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 dividend = 32'd50; divisor = 32'd5;
      wait_done(33, 32);
      @(posedge clk);
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(33, 32);

      // reset in the middle of a calculation aborts with no done pulse
      @(negedge clk);
      dividend = 32'd100; divisor = 32'd7; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_quotient", quotient, 32'h0);
      chk("abort_remainder", remainder, 32'h0);
      chk("abort_dbz", {31'b0, div_by_zero}, 32'h0);
      chk("abort_busy", {31'b0, busy}, 32'h0);
      chk("abort_done", {31'b0, done}, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      dn = 0;
      repeat (40) begin
         @(negedge clk);
         if (done || busy) dn++;
      end
      chk("abort_no_activity", dn, 0);

      run_op(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 33, 32);

      repeat (3) @(negedge clk);
      chk("pending_expected", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
